ysyx_25060170_wbu: RTL and testbench
====================================

// Module: ysyx_25060170_wbu
// PURPOSE
//  Write-back unit; the consumer side of the EXU->WBU valid/ready interface. Accepts one EXU result at a time.
//  For loads, fetches and extracts the data word. Writes the GPR file and pulses commit_valid to the IFU.
//  The IFU then fetches from commit_next_pc (multi-cycle core, one instruction in flight).
// PARAMETERS
//  XLEN        32  datapath / address width
//  REG_ADDR_W  5   GPR index width
// PORTS
//  clk             in   1     core clock
//  rst_n           in   1     synchronous reset, active-low
//  exu_valid       in   1     EXU result valid
//  exu_ready       out  1     WBU can accept
//  exu_res         in   XLEN  ALU result, or load effective address
//  exu_pc          in   XLEN  instruction PC
//  exu_next_pc     in   XLEN  resolved next PC
//  exu_rd          in   5     destination register
//  exu_rf_we       in   1     instruction writes rd
//  exu_wb_sel      in   2     0=ALU, 1=MEM, 2=PC+4, 3=reserved (treated as ALU)
//  exu_mem_op      in   3     load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//  mem_req_valid   out  1     read request
//  mem_req_ready   in   1     memory accepts request
//  mem_req_addr    out  XLEN  word-aligned address ({res[31:2],2'b00})
//  mem_resp_valid  in   1     read data valid
//  mem_resp_data   in   XLEN  read word
//  rf_we/rf_waddr/rf_wdata out 1/5/XLEN  GPR write port
//  commit_valid    out  1     instruction retired (1-cycle pulse)
//  commit_next_pc  out  XLEN  next PC of retired instruction
// BEHAVIOUR
//  - FSM states: IDLE, REQ, WAIT, COMMIT. exu_ready=1 only in IDLE.
//  - IDLE: on exu_valid&&exu_ready, latch all exu_* fields. wb_sel==MEM -> REQ; otherwise -> COMMIT.
//  - REQ: mem_req_valid=1; mem_req_addr stays stable until mem_req_ready; then -> WAIT.
//  - WAIT: on mem_resp_valid, latch the extracted load data, then -> COMMIT. A response never arrives in the REQ-handshake cycle.
//  - Load extraction: byte lane = res[1:0]; half lane = res[1]; word ignores res[1:0].
//    LB/LH sign-extend; LBU/LHU zero-extend. Unlisted mem_op codes behave as LW.
//  - COMMIT (exactly 1 cycle):
//    - commit_valid=1.
//    - rf_we = latched rf_we && rd!=0; rf_waddr=rd.
//    - rf_wdata = ALU: res; MEM: load data; PC+4: pc+4 mod 2^32.
//    - Then -> IDLE.
//  - Latency: non-load accept at cycle N -> commit at N+1. Load: commit 1 cycle after the mem_resp_valid cycle. Max throughput 1 instruction per 2 cycles.
//  - Outputs are registered/decoded from state; rf_we and commit_valid are 0 outside COMMIT.
//  - Reset (rst_n=0 at clk edge, any state):
//    - state=IDLE; all latched fields cleared.
//    - mem_req_valid, rf_we, commit_valid = 0; exu_ready=0 while rst_n=0.
//    - An in-flight load is abandoned; a stray mem_resp_valid in IDLE is ignored.
// CONFIGURATION
//  YSYX_25060170_WBU_DIFFTEST_EN
//  - Defined: adds outputs diff_pc(XLEN), diff_rd(5), diff_wdata(XLEN), diff_we(1). These mirror exu_pc/rd/rf_wdata/rf_we during COMMIT; 0 otherwise. Used by the difftest/trace harness.
//  - Undefined: ports and logic absent; core behaviour identical.
// STRUCTURE
//  - ysyx_25060170_pkg holds: wb_sel codes, load funct3 constants, FSM state enum (2-bit).
//  - Sub-module ysyx_25060170_load_ext: combinational lane select + sign/zero extension (addr[1:0], mem_op, word -> XLEN).
// TESTING
//  1. ALU: res=0x12345678, rd=5, sel=0 -> next cycle: rf_we=1, waddr=5, wdata=0x12345678, commit_valid=1. exu_ready low exactly 1 cycle.
//  2. LB at res=0x80000003, resp=0x80FF7F01 -> mem_req_addr=0x80000000, wdata=0xFFFFFF80. Same with LBU -> 0x00000080.
//  3. LH at res=0x80000002, resp=0x80010000 -> 0xFFFF8001 (LHU: 0x00008001). mem_req_ready held low 3 cycles -> req_valid/addr stable throughout.
//  4. JAL: sel=2, rd=0 -> commit_valid=1, rf_we=0. With rd=1, pc=0xFFFFFFFC -> wdata=0x00000000.
//  5. rst_n low during WAIT -> next cycle IDLE, no rf_we/commit. Late mem_resp_valid then ignored.
//  6. exu_valid held high with 3 queued ALU ops -> each accepted only after the previous commit; commits on cycles N+1, N+3, N+5.

Source files
------------

// File: rtl/ysyx_25060170_pkg.sv
// Shared constants for the write-back unit: wb_sel codes, load funct3 codes and FSM state encoding.
package ysyx_25060170_pkg;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;
   localparam logic [1:0] WB_RSV = 2'd3;

   localparam logic [2:0] LD_LB  = 3'b000;
   localparam logic [2:0] LD_LH  = 3'b001;
   localparam logic [2:0] LD_LW  = 3'b010;
   localparam logic [2:0] LD_LBU = 3'b100;
   localparam logic [2:0] LD_LHU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ    = 2'd1,
      ST_WAIT   = 2'd2,
      ST_COMMIT = 2'd3
   } wbu_state_e;

endpackage

// File: rtl/ysyx_25060170_wbu_if.sv
// EXU->WBU result handshake. The EXU drives the master side, the WBU consumes on the slave side.
interface ysyx_25060170_wbu_if #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
);
   logic                  valid;
   logic                  ready;
   logic [XLEN-1:0]       res;
   logic [XLEN-1:0]       pc;
   logic [XLEN-1:0]       next_pc;
   logic [REG_ADDR_W-1:0] rd;
   logic                  rf_we;
   logic [1:0]            wb_sel;
   logic [2:0]            mem_op;

   modport master (
      output valid, res, pc, next_pc, rd, rf_we, wb_sel, mem_op,
      input  ready
   );

   modport slave (
      input  valid, res, pc, next_pc, rd, rf_we, wb_sel, mem_op,
      output ready
   );
endinterface

// File: rtl/ysyx_25060170_load_ext.sv
// Load data extraction: picks the byte/half lane out of a read word and sign- or zero-extends it.
module ysyx_25060170_load_ext
   import ysyx_25060170_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [1:0]      addr,
   input  logic [2:0]      mem_op,
   input  logic [XLEN-1:0] word,
   output logic [XLEN-1:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word[7:0];
      case (addr)
         2'd0:    byte_sel = word[7:0];
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         default: byte_sel = word[31:24];
      endcase
      half_sel = addr[1] ? word[31:16] : word[15:0];
   end

   // Any funct3 outside the listed loads is handled as a full-word load.
   always_comb begin
      data = word;
      case (mem_op)
         LD_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         LD_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
         LD_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
         LD_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
         LD_LW:   data = word;
         default: data = word;
      endcase
   end

endmodule

// File: rtl/ysyx_25060170_wbu.sv
// Write-back unit: accepts one EXU result, performs the load if needed, writes the GPR and retires.
// Optional YSYX_25060170_WBU_DIFFTEST_EN adds the diff_* trace outputs.
//
// state  | meaning
// IDLE   | ready for a new EXU result
// REQ    | load read request outstanding, waiting for mem_req_ready
// WAIT   | request accepted, waiting for mem_resp_valid
// COMMIT | one-cycle retire: GPR write and commit pulse
module ysyx_25060170_wbu
   import ysyx_25060170_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   ysyx_25060170_wbu_if.slave    exu,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic [XLEN-1:0]       mem_req_addr,
   input  logic                  mem_resp_valid,
   input  logic [XLEN-1:0]       mem_resp_data,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_waddr,
   output logic [XLEN-1:0]       rf_wdata,
   output logic                  commit_valid,
   output logic [XLEN-1:0]       commit_next_pc
`ifdef YSYX_25060170_WBU_DIFFTEST_EN
   ,
   output logic [XLEN-1:0]       diff_pc,
   output logic [REG_ADDR_W-1:0] diff_rd,
   output logic [XLEN-1:0]       diff_wdata,
   output logic                  diff_we
`endif
);

   wbu_state_e            state_q;
   logic [XLEN-1:0]       res_q;
   logic [XLEN-1:0]       pc_q;
   logic [XLEN-1:0]       next_pc_q;
   logic [REG_ADDR_W-1:0] rd_q;
   logic                  rf_we_q;
   logic [1:0]            wb_sel_q;
   logic [2:0]            mem_op_q;
   logic [XLEN-1:0]       load_q;
   logic [XLEN-1:0]       ext_data;

   ysyx_25060170_load_ext #(.XLEN(XLEN)) u_load_ext (
      .addr   (res_q[1:0]),
      .mem_op (mem_op_q),
      .word   (mem_resp_data),
      .data   (ext_data)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         res_q     <= '0;
         pc_q      <= '0;
         next_pc_q <= '0;
         rd_q      <= '0;
         rf_we_q   <= 1'b0;
         wb_sel_q  <= WB_ALU;
         mem_op_q  <= '0;
         load_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (exu.valid) begin
                  res_q     <= exu.res;
                  pc_q      <= exu.pc;
                  next_pc_q <= exu.next_pc;
                  rd_q      <= exu.rd;
                  rf_we_q   <= exu.rf_we;
                  wb_sel_q  <= exu.wb_sel;
                  mem_op_q  <= exu.mem_op;
                  state_q   <= (exu.wb_sel == WB_MEM) ? ST_REQ : ST_COMMIT;
               end
            end
            ST_REQ: begin
               if (mem_req_ready) state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               if (mem_resp_valid) begin
                  load_q  <= ext_data;
                  state_q <= ST_COMMIT;
               end
            end
            ST_COMMIT: state_q <= ST_IDLE;
            default:   state_q <= ST_IDLE;
         endcase
      end
   end

   // ready is gated by rst_n so nothing is accepted on a reset edge.
   assign exu.ready      = rst_n && (state_q == ST_IDLE);
   assign mem_req_valid  = (state_q == ST_REQ);
   assign mem_req_addr   = {res_q[XLEN-1:2], 2'b00};
   assign commit_valid   = (state_q == ST_COMMIT);
   assign commit_next_pc = next_pc_q;
   assign rf_we          = commit_valid && rf_we_q && (rd_q != '0);
   assign rf_waddr       = rd_q;

   always_comb begin
      rf_wdata = res_q;
      case (wb_sel_q)
         WB_MEM:         rf_wdata = load_q;
         WB_PC4:         rf_wdata = pc_q + XLEN'(4);
         WB_ALU, WB_RSV: rf_wdata = res_q;
         default:        rf_wdata = res_q;
      endcase
   end

`ifdef YSYX_25060170_WBU_DIFFTEST_EN
   assign diff_pc    = commit_valid ? pc_q : '0;
   assign diff_rd    = commit_valid ? rd_q : '0;
   assign diff_wdata = commit_valid ? rf_wdata : '0;
   assign diff_we    = rf_we;
`endif

endmodule

// File: tb/tb_ysyx_25060170_wbu.sv
// Self-checking bench for ysyx_25060170_wbu: directed scenarios plus randomized operations
// checked against a lane/extension reference model.
module tb_ysyx_25060170_wbu;

   logic        clk;
   logic        rst_n;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        commit_valid;
   logic [31:0] commit_next_pc;
`ifdef YSYX_25060170_WBU_DIFFTEST_EN
   logic [31:0] diff_pc;
   logic [4:0]  diff_rd;
   logic [31:0] diff_wdata;
   logic        diff_we;
`endif

   int checks = 0;
   int errors = 0;

   ysyx_25060170_wbu_if #(.XLEN(32), .REG_ADDR_W(5)) exu_if ();

   ysyx_25060170_wbu #(.XLEN(32), .REG_ADDR_W(5)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .exu            (exu_if),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data),
      .rf_we          (rf_we),
      .rf_waddr       (rf_waddr),
      .rf_wdata       (rf_wdata),
      .commit_valid   (commit_valid),
      .commit_next_pc (commit_next_pc)
`ifdef YSYX_25060170_WBU_DIFFTEST_EN
      ,
      .diff_pc        (diff_pc),
      .diff_rd        (diff_rd),
      .diff_wdata     (diff_wdata),
      .diff_we        (diff_we)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: value the GPR should receive, computed from shift/mask arithmetic.
   function automatic logic [31:0] model_wdata(input logic [1:0] sel, input logic [2:0] op,
                                               input logic [31:0] res, input logic [31:0] pc,
                                               input logic [31:0] resp);
      logic [31:0] b, h;
      b = (resp >> (8 * res[1:0])) & 32'hFF;
      h = (resp >> (16 * res[1])) & 32'hFFFF;
      if (sel == 2'd2) return pc + 32'd4;
      if (sel != 2'd1) return res;
      case (op)
         3'b000:  return (b >= 32'd128) ? (b + 32'hFFFF_FF00) : b;
         3'b001:  return (h >= 32'd32768) ? (h + 32'hFFFF_0000) : h;
         3'b100:  return b;
         3'b101:  return h;
         default: return resp;
      endcase
   endfunction

   task automatic drive_exu(input logic [1:0] sel, input logic [2:0] op, input logic [31:0] res,
                            input logic [31:0] pc, input logic [31:0] npc, input logic [4:0] rd,
                            input logic we);
      exu_if.valid   = 1'b1;
      exu_if.wb_sel  = sel;
      exu_if.mem_op  = op;
      exu_if.res     = res;
      exu_if.pc      = pc;
      exu_if.next_pc = npc;
      exu_if.rd      = rd;
      exu_if.rf_we   = we;
   endtask

   // One instruction from accept to retire, with explicit memory stall lengths.
   task automatic do_op(input string tag, input logic [1:0] sel, input logic [2:0] op,
                        input logic [31:0] res, input logic [31:0] pc, input logic [31:0] npc,
                        input logic [4:0] rd, input logic we, input logic [31:0] resp,
                        input int req_dly, input int resp_dly, input logic [31:0] exp_wdata);
      logic exp_we;
      exp_we = we && (rd != 5'd0);
      check({tag, ".ready_idle"}, {31'd0, exu_if.ready}, 32'd1);
      drive_exu(sel, op, res, pc, npc, rd, we);
      step();
      exu_if.valid = 1'b0;
      if (sel == 2'd1) begin
         for (int i = 0; i < req_dly; i++) begin
            check({tag, ".req_valid"}, {31'd0, mem_req_valid}, 32'd1);
            check({tag, ".req_addr"}, mem_req_addr, res & 32'hFFFF_FFFC);
            step();
         end
         check({tag, ".req_valid"}, {31'd0, mem_req_valid}, 32'd1);
         check({tag, ".req_addr"}, mem_req_addr, res & 32'hFFFF_FFFC);
         mem_req_ready = 1'b1;
         step();
         mem_req_ready = 1'b0;
         for (int i = 0; i < resp_dly; i++) begin
            check({tag, ".wait_no_commit"}, {31'd0, commit_valid}, 32'd0);
            check({tag, ".wait_no_req"}, {31'd0, mem_req_valid}, 32'd0);
            step();
         end
         mem_resp_valid = 1'b1;
         mem_resp_data  = resp;
         step();
         mem_resp_valid = 1'b0;
         mem_resp_data  = $urandom;
      end
      check({tag, ".commit"}, {31'd0, commit_valid}, 32'd1);
      check({tag, ".rf_we"}, {31'd0, rf_we}, {31'd0, exp_we});
      check({tag, ".waddr"}, {27'd0, rf_waddr}, {27'd0, rd});
      check({tag, ".wdata"}, rf_wdata, exp_wdata);
      check({tag, ".next_pc"}, commit_next_pc, npc);
      check({tag, ".ready_busy"}, {31'd0, exu_if.ready}, 32'd0);
`ifdef YSYX_25060170_WBU_DIFFTEST_EN
      check({tag, ".diff_pc"}, diff_pc, pc);
      check({tag, ".diff_we"}, {31'd0, diff_we}, {31'd0, exp_we});
      check({tag, ".diff_wdata"}, diff_wdata, exp_wdata);
`endif
      step();
      check({tag, ".commit_end"}, {31'd0, commit_valid}, 32'd0);
      check({tag, ".rf_we_end"}, {31'd0, rf_we}, 32'd0);
      check({tag, ".ready_back"}, {31'd0, exu_if.ready}, 32'd1);
`ifdef YSYX_25060170_WBU_DIFFTEST_EN
      check({tag, ".diff_pc_end"}, diff_pc, 32'd0);
`endif
   endtask

   logic [31:0] q_res [3];
   logic [4:0]  q_rd  [3];

   initial begin
      logic [1:0]  sel;
      logic [2:0]  op;
      logic [31:0] res, pc, resp;
      logic [4:0]  rd;
      logic        we;
      int          idx;

      rst_n          = 1'b0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      drive_exu(2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
      exu_if.valid   = 1'b0;
      step();
      step();
      check("reset.ready", {31'd0, exu_if.ready}, 32'd0);
      check("reset.commit", {31'd0, commit_valid}, 32'd0);
      check("reset.rf_we", {31'd0, rf_we}, 32'd0);
      check("reset.req", {31'd0, mem_req_valid}, 32'd0);
      rst_n = 1'b1;
      step();
      check("reset.ready_after", {31'd0, exu_if.ready}, 32'd1);

      do_op("alu", 2'd0, 3'd0, 32'h1234_5678, 32'h8000_0000, 32'h8000_0004, 5'd5, 1'b1,
            32'd0, 0, 0, 32'h1234_5678);
      do_op("lb", 2'd1, 3'b000, 32'h8000_0003, 32'h8000_0010, 32'h8000_0014, 5'd7, 1'b1,
            32'h80FF_7F01, 0, 1, 32'hFFFF_FF80);
      do_op("lbu", 2'd1, 3'b100, 32'h8000_0003, 32'h8000_0010, 32'h8000_0014, 5'd7, 1'b1,
            32'h80FF_7F01, 1, 0, 32'h0000_0080);
      do_op("lh", 2'd1, 3'b001, 32'h8000_0002, 32'h8000_0020, 32'h8000_0024, 5'd9, 1'b1,
            32'h8001_0000, 3, 2, 32'hFFFF_8001);
      do_op("lhu", 2'd1, 3'b101, 32'h8000_0002, 32'h8000_0020, 32'h8000_0024, 5'd9, 1'b1,
            32'h8001_0000, 3, 0, 32'h0000_8001);
      do_op("jal_rd0", 2'd2, 3'd0, 32'h0000_1000, 32'h8000_0100, 32'h8000_0200, 5'd0, 1'b1,
            32'd0, 0, 0, 32'h8000_0104);
      do_op("jal_wrap", 2'd2, 3'd0, 32'h0000_1000, 32'hFFFF_FFFC, 32'h8000_0000, 5'd1, 1'b1,
            32'd0, 0, 0, 32'h0000_0000);
      do_op("sel_rsv", 2'd3, 3'd0, 32'hCAFE_F00D, 32'h8000_0300, 32'h8000_0304, 5'd3, 1'b1,
            32'd0, 0, 0, 32'hCAFE_F00D);

      // Reset while a load is waiting for its response.
      drive_exu(2'd1, 3'b010, 32'h8000_0040, 32'h8000_0400, 32'h8000_0404, 5'd4, 1'b1);
      step();
      exu_if.valid  = 1'b0;
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      step();
      check("rstwait.in_wait", {31'd0, mem_req_valid}, 32'd0);
      rst_n = 1'b0;
      step();
      check("rstwait.commit", {31'd0, commit_valid}, 32'd0);
      check("rstwait.rf_we", {31'd0, rf_we}, 32'd0);
      check("rstwait.ready_low", {31'd0, exu_if.ready}, 32'd0);
      rst_n          = 1'b1;
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'hDEAD_BEEF;
      step();
      mem_resp_valid = 1'b0;
      check("rstwait.late_commit", {31'd0, commit_valid}, 32'd0);
      check("rstwait.late_rf_we", {31'd0, rf_we}, 32'd0);
      check("rstwait.ready_idle", {31'd0, exu_if.ready}, 32'd1);
      step();
      check("rstwait.still_quiet", {31'd0, commit_valid}, 32'd0);

      // Three back-to-back ALU ops with valid held high: commits two cycles apart.
      for (int i = 0; i < 3; i++) begin
         q_res[i] = $urandom;
         q_rd[i]  = 5'($urandom_range(1, 31));
      end
      idx = 0;
      drive_exu(2'd0, 3'd0, q_res[0], 32'h8000_1000, 32'h8000_1004, q_rd[0], 1'b1);
      for (int k = 1; k <= 7; k++) begin
         step();
         check("queue.commit", {31'd0, commit_valid}, {31'd0, (k % 2 == 1) && (k <= 5)});
         if ((k % 2 == 1) && (k <= 5)) begin
            check("queue.wdata", rf_wdata, q_res[idx]);
            check("queue.waddr", {27'd0, rf_waddr}, {27'd0, q_rd[idx]});
            idx++;
            if (idx < 3)
               drive_exu(2'd0, 3'd0, q_res[idx], 32'h8000_1000, 32'h8000_1004, q_rd[idx], 1'b1);
            else
               exu_if.valid = 1'b0;
         end
      end

      for (int n = 0; n < 60; n++) begin
         sel  = 2'($urandom_range(0, 3));
         op   = 3'($urandom_range(0, 7));
         res  = $urandom;
         pc   = $urandom;
         rd   = 5'($urandom_range(0, 31));
         we   = 1'($urandom_range(0, 1));
         resp = $urandom;
         do_op("rand", sel, op, res, pc, $urandom, rd, we, resp,
               $urandom_range(0, 3), $urandom_range(0, 3),
               model_wdata(sel, op, res, pc, resp));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
